// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and the latched request record.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WORD = 2'd1,
    WR_WORD = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Only the byte offset is kept; the word index lives in the mem_a register.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends a load lane from a memory word,
// and merges a store lane into a word for sub-word read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word[{off, 3'b000} +: 8];
    lane_h    = off[1] ? word[31:16] : word[15:0];
    load_data = word;
    merged    = wdata;
    case (funct3)
      F3_B:  load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU: load_data = {24'h0, lane_b};
      F3_H:  load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU: load_data = {16'h0, lane_h};
      default: ;
    endcase
    // Only SB/SH reach the merge path; every other code stores the full word.
    case (funct3)
      F3_B: begin
        merged = word;
        merged[{off, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged = word;
        if (off[1]) merged[31:16] = wdata[15:0];
        else        merged[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32I load/store initiator for a word-addressed data memory. One
// transaction at a time; sub-word stores are done as read-modify-write.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state, nxt;
  lsu_req_t    req_q;
  logic [31:0] rdata_q, a_q, wd_q;
  logic        err_q, acc, bad;
  logic [31:0] load_data, merged;

  assign acc = req_valid && (state == IDLE);

  always_comb begin
    bad = 1'b0;
    case (req_funct3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = req_addr[0];
      F3_W:  bad = |req_addr[1:0];
      F3_BU: bad = req_we;
      F3_HU: bad = req_we | req_addr[0];
      default: bad = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= $unsigned(MEM_WORDS)) bad = 1'b1;
  end

  lsu_align u_align (
    .funct3    (req_q.funct3),
    .off       (req_q.off),
    .word      (mem_rd),
    .wdata     (wd_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) begin
        if (bad)                                nxt = RESP;
        else if (req_we && req_funct3 == F3_W)  nxt = WR_WORD;
        else                                    nxt = RD_WORD;
      end
      RD_WORD: nxt = req_q.we ? WR_WORD : RESP;
      WR_WORD: nxt = RESP;
      RESP:    if (resp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Write enable is decoded from state so reset kills it combinationally.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    mem_we     = (state == WR_WORD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
    end else begin
      if (acc) begin
        req_q   <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
        err_q   <= bad;
        rdata_q <= '0;
        if (!bad) begin
          a_q <= {2'b00, req_addr[31:2]};
          if (req_we) wd_q <= req_wdata;
        end
      end
      if (state == RD_WORD) begin
        if (req_q.we) wd_q    <= merged;
        else          rdata_q <= load_data;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = a_q;
  assign mem_wd     = wd_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Randomized + directed bench for data_mem_lsu against an array-based
// reference model of byte-addressed little-endian RV32I loads/stores.
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic        load_en = 1'b0;
  int          we_cnt;
  logic [31:0] wr_a, wr_d;
  int          total = 0, bad = 0;

  data_mem_lsu #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[4:0]];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (mem_we) begin
      we_cnt = we_cnt + 1;
      wr_a   = mem_a;
      wr_d   = mem_wd;
      mem[mem_a[4:0]] <= mem_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: computes response and updates ref_mem from the ISA rules directly.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int lat, output int nwr, output logic [31:0] wa,
                       output logic [31:0] wdw);
    longint unsigned idx = addr / 4;
    int    off  = addr % 4;
    int    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    logic  legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5)));
    logic [31:0] w, v, mask;
    err = !legal || idx >= 32 || (off % size) != 0;
    rd = 0; nwr = 0; wa = 0; wdw = 0; lat = 1;
    if (err) return;
    w = ref_mem[idx];
    if (!we) begin
      lat = 2;
      v = w >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      end
      rd = v;
    end else begin
      lat = (size == 4) ? 2 : 3;
      if (size == 4) v = wd;
      else begin
        mask = (size == 1) ? 32'hFF : 32'hFFFF;
        v = (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      end
      ref_mem[idx] = v;
      nwr = 1; wa = 32'(idx); wdw = v;
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold);
    logic [31:0] e_rd, e_wa, e_wd, got_rd;
    logic        e_err;
    int          e_lat, e_nwr, lat;
    model(we, f3, addr, wd, e_rd, e_err, e_lat, e_nwr, e_wa, e_wd);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b0; we_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rdata", resp_rdata, e_rd);
    chk("err", {31'b0, resp_err}, {31'b0, e_err});
    got_rd = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, got_rd);
      chk("hold_busy", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("back_idle", {30'b0, resp_valid, req_ready}, 32'd1);
    chk("we_pulses", 32'(we_cnt), 32'(e_nwr));
    if (e_nwr == 1) begin
      chk("wr_addr", wr_a, e_wa);
      chk("wr_data", wr_d, e_wd);
    end
  endtask

  initial begin
    logic [2:0] f3s [8];
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[2] = 32'h8A7F_1234;
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_en = 1'b0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_a", mem_a, 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    @(negedge clk) rst = 1'b1;

    run(1'b0, 3'd2, 32'd8, 32'd0, 0);
    run(1'b0, 3'd0, 32'd11, 32'd0, 0);
    run(1'b0, 3'd4, 32'd11, 32'd0, 0);
    run(1'b0, 3'd1, 32'd10, 32'd0, 0);
    run(1'b1, 3'd0, 32'd9, 32'h0000_00EE, 0);
    run(1'b0, 3'd2, 32'd8, 32'd0, 0);
    run(1'b0, 3'd2, 32'd6, 32'd0, 0);
    run(1'b1, 3'd1, 32'd5, 32'h1234_5678, 0);
    run(1'b0, 3'd2, 32'd128, 32'd0, 0);
    run(1'b1, 3'd4, 32'd4, 32'd1, 0);
    run(1'b1, 3'd2, 32'd124, 32'hDEAD_BEEF, 1);
    run(1'b0, 3'd5, 32'd126, 32'd0, 5);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 131));
      run(1'($urandom_range(0, 1)), f3s[($urandom_range(0, 9) == 0) ? $urandom_range(5, 7)
                                                                    : $urandom_range(0, 4)],
          a, $urandom, $urandom_range(0, 3));
    end

    // Reset while an SB sits in WR_WORD: the write must never land.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'd21;
    req_wdata = 32'h0000_0055; we_cnt = 0;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_we", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    #1 chk("rst_we_drop", {31'b0, mem_we}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_resp", {30'b0, resp_valid, mem_we}, 32'd0);
    end
    chk("rst_no_write", 32'(we_cnt), 32'd0);
    chk("rst_word", mem[5], ref_mem[5]);

    for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
